// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: pin and byte-store bundle for the SPI NOR flash emulator.
//   spi_clk, spi_cs_n, io_in : flash-side pins from the SPI initiator
//   io_out, io_oe            : pad output values and enables (1 = drive)
//   rd_en, rd_addr, rd_data  : synchronous byte store port (data 1 clk after rd_en)
//   busy, cmd_err            : transaction-active flag and bad-opcode pulse
// slave modport is the responder; master modport is the initiator/store side.
interface spi_flash_responder_if #(
  parameter int unsigned ADDR_WIDTH = 20
) ();
  logic                  spi_clk;
  logic                  spi_cs_n;
  logic [1:0]            io_in;
  logic [1:0]            io_out;
  logic [1:0]            io_oe;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;
  logic                  busy;
  logic                  cmd_err;

  modport master (
    output spi_clk, spi_cs_n, io_in, rd_data,
    input  io_out, io_oe, rd_en, rd_addr, busy, cmd_err
  );

  modport slave (
    input  spi_clk, spi_cs_n, io_in, rd_data,
    output io_out, io_oe, rd_en, rd_addr, busy, cmd_err
  );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI NOR flash emulator serving dual-I/O reads (0xBB)
// from an external synchronous byte store.
//   clk   : system clock, at least 8x the SPI clock
//   RESET : asynchronous, active-high reset
//   bus   : spi_flash_responder_if.slave (SPI pins, pad drive, byte store, busy, cmd_err)
// Optional feature macro SPI_FLASH_RESPONDER_FASTREAD_EN adds single-I/O fast read (0x0B).
module spi_flash_responder #(
  parameter int unsigned ADDR_WIDTH = 20
) (
  input logic                  clk,
  input logic                  RESET,
  spi_flash_responder_if.slave bus
);

`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
  localparam int unsigned CntW = 5;
  typedef enum logic [3:0] {
    StIdle, StCmd, StAddr, StMode, StData, StIgnore, StAddrS, StDummy, StDataS
  } state_e;
`else
  localparam int unsigned CntW = 4;
  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StMode, StData, StIgnore
  } state_e;
`endif

  // Pin synchronizers: {spi_clk, spi_cs_n, io_in[1:0]}. CS resets to the low value so a
  // CS still held low at reset release never looks like a fresh transaction start.
  logic [3:0] sync0_q, sync1_q;
  logic       sclk_prev_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sync0_q     <= {bus.spi_clk, bus.spi_cs_n, bus.io_in};
      sync1_q     <= sync0_q;
      sclk_prev_q <= sync1_q[3];
    end
  end

  logic       sclk_s, cs_n_s, sclk_rise, sclk_fall;
  logic [1:0] io_s;

  assign sclk_s    = sync1_q[3];
  assign cs_n_s    = sync1_q[2];
  assign io_s      = sync1_q[1:0];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [23:0]           addr_q, addr_d;
  logic [7:0]            dshift_q, dshift_d;
  logic [7:0]            hold_q, hold_d;
  logic [1:0]            io_out_q, io_out_d;
  logic [1:0]            io_oe_q, io_oe_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  cmd_err_q, cmd_err_d;
  // Set once CS has been seen high; gates IDLE->CMD so a reset mid-transaction never resumes.
  logic                  armed_q, armed_d;

  logic [7:0]  cmd_next;
  logic [23:0] addr_dual_next;

  assign cmd_next       = {cmd_q[6:0], io_s[0]};
  assign addr_dual_next = {addr_q[21:0], io_s[1], io_s[0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    dshift_d   = dshift_q;
    io_out_d   = io_out_q;
    io_oe_d    = io_oe_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    cmd_err_d  = 1'b0;
    armed_d    = armed_q;
    rd_valid_d = rd_en_q;
    hold_d     = rd_valid_q ? bus.rd_data : hold_q;

    if (cs_n_s) begin
      // CS high beats any SPI edge in the same sample; drop everything in flight.
      state_d  = StIdle;
      cnt_d    = '0;
      cmd_d    = '0;
      addr_d   = '0;
      dshift_d = '0;
      io_out_d = '0;
      io_oe_d  = '0;
      armed_d  = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (armed_q) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end

        StCmd: begin
          if (sclk_rise) begin
            cmd_d = cmd_next;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(7)) begin
              cnt_d = '0;
              if (cmd_next == 8'hBB) begin
                state_d = StAddr;
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
              end else if (cmd_next == 8'h0B) begin
                state_d = StAddrS;
`endif
              end else begin
                cmd_err_d = 1'b1;
                state_d   = StIgnore;
              end
            end
          end
        end

        StAddr: begin
          if (sclk_rise) begin
            addr_d = addr_dual_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(11)) begin
              cnt_d     = '0;
              rd_en_d   = 1'b1;
              rd_addr_d = addr_dual_next[ADDR_WIDTH-1:0];
              state_d   = StMode;
            end
          end
        end

        StMode: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(3)) begin
              cnt_d   = '0;
              state_d = StData;
            end
          end
        end

        StData: begin
          if (sclk_fall) begin
            if (cnt_q == '0) begin
              // Byte boundary: load the held byte and prefetch the next address.
              io_out_d  = hold_q[7:6];
              io_oe_d   = 2'b11;
              dshift_d  = {hold_q[5:0], 2'b00};
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end else begin
              io_out_d = dshift_q[7:6];
              dshift_d = {dshift_q[5:0], 2'b00};
            end
            cnt_d = (cnt_q == CntW'(3)) ? '0 : cnt_q + CntW'(1);
          end
        end

        StIgnore: begin
        end

`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
        StAddrS: begin
          if (sclk_rise) begin
            addr_d = {addr_q[22:0], io_s[0]};
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_q == CntW'(23)) begin
              cnt_d     = '0;
              rd_en_d   = 1'b1;
              rd_addr_d = addr_q[ADDR_WIDTH-2:0] == '0 && ADDR_WIDTH == 1 ?
                          rd_addr_q : {addr_q[ADDR_WIDTH-2:0], io_s[0]};
              state_d   = StDummy;
            end
          end
        end

        StDummy: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(7)) begin
              cnt_d   = '0;
              state_d = StDataS;
            end
          end
        end

        StDataS: begin
          if (sclk_fall) begin
            if (cnt_q == '0) begin
              io_out_d  = {hold_q[7], 1'b0};
              io_oe_d   = 2'b10;
              dshift_d  = {hold_q[6:0], 1'b0};
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            end else begin
              io_out_d = {dshift_q[7], 1'b0};
              dshift_d = {dshift_q[6:0], 1'b0};
            end
            cnt_d = (cnt_q == CntW'(7)) ? '0 : cnt_q + CntW'(1);
          end
        end
`endif

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      dshift_q   <= '0;
      hold_q     <= '0;
      io_out_q   <= '0;
      io_oe_q    <= '0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      cmd_err_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      dshift_q   <= dshift_d;
      hold_q     <= hold_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      cmd_err_q  <= cmd_err_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.io_out  = io_out_q;
  assign bus.io_oe   = io_oe_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.cmd_err = cmd_err_q;
  assign bus.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: drives SPI mode-0 transactions at 16 clk per
// SPI period and checks returned bytes and store addresses against a byte-store model.
module tb_spi_flash_responder;
  localparam int unsigned AW    = 20;
  localparam int unsigned AMask = (1 << AW) - 1;

  logic clk;
  logic RESET;

  spi_flash_responder_if #(.ADDR_WIDTH(AW)) bus ();

  spi_flash_responder #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Byte store model: explicit entries override a fixed address-derived pattern.
  logic [7:0] mem [int unsigned];

  function automatic logic [7:0] store_rd(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 8'((a * 37) ^ (a >> 8));
  endfunction

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= store_rd({12'd0, bus.rd_addr});
  end

  // Monitors, written only here.
  int unsigned   err_cnt;
  int unsigned   oe_cnt;
  logic [AW-1:0] rd_log [$];

  always @(negedge clk) begin
    if (bus.cmd_err) err_cnt++;
    if (bus.io_oe != 2'b00) oe_cnt++;
    if (bus.rd_en) rd_log.push_back(bus.rd_addr);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- SPI primitives ----------------
  logic [7:0] got_q [$];
  int         oe_bad;

  task automatic spi_cycle(input logic [1:0] drv, output logic [1:0] got,
                           output logic [1:0] oe);
    bus.io_in = drv;
    repeat (8) @(negedge clk);
    got = bus.io_out;
    oe  = bus.io_oe;
    bus.spi_clk = 1'b1;
    repeat (8) @(negedge clk);
    bus.spi_clk = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_op(input logic [7:0] op);
    logic [1:0] g, oe;
    for (int i = 7; i >= 0; i--) spi_cycle({1'b0, op[i]}, g, oe);
  endtask

  task automatic send_addr_dual(input logic [23:0] a);
    logic [1:0] g, oe;
    for (int i = 11; i >= 0; i--) spi_cycle({a[2*i+1], a[2*i]}, g, oe);
  endtask

  task automatic send_cycles(input int n, input logic [1:0] drv);
    logic [1:0] g, oe;
    for (int i = 0; i < n; i++) spi_cycle(drv, g, oe);
  endtask

  task automatic read_dual(input int nbytes);
    logic [1:0] g, oe;
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      b = '0;
      for (int d = 0; d < 4; d++) begin
        spi_cycle(2'b00, g, oe);
        b = {b[5:0], g};
        if (oe !== 2'b11) oe_bad++;
      end
      got_q.push_back(b);
    end
  endtask

  // Full 0xBB transaction; r0 is the rd_log index of its first store read.
  task automatic xfer_dual(input logic [23:0] a, input int nbytes, output int r0);
    got_q.delete();
    oe_bad = 0;
    r0 = rd_log.size();
    cs_low();
    send_op(8'hBB);
    send_addr_dual(a);
    send_cycles(4, 2'b11);
    read_dual(nbytes);
    cs_high();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET        = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.io_in    = 2'b00;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.io_out !== 2'b00) begin
      n_fail++; $display("FAIL reset_io_out: got %b want 00", bus.io_out);
    end
    n_checks++;
    if (bus.io_oe !== 2'b00) begin
      n_fail++; $display("FAIL reset_io_oe: got %b want 00", bus.io_oe);
    end
    n_checks++;
    if (bus.rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en);
    end
    n_checks++;
    if (bus.rd_addr !== '0) begin
      n_fail++; $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_checks++;
    if (bus.cmd_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_err: got %b want 0", bus.cmd_err);
    end
    RESET = 1'b0;
    repeat (6) @(negedge clk);
    // busy follows CS with a 3-clk pin-to-action latency
    bus.spi_cs_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_rise_early: got %b want 0", bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_rise: got %b want 1", bus.busy);
    end
    bus.spi_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_fall_early: got %b want 1", bus.busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_fall: got %b want 0", bus.busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_dual_read();
    int r0;
    logic [7:0]    exp_b;
    logic [AW-1:0] exp_a, got_a;
    mem[32'h01234] = 8'h11;
    mem[32'h01235] = 8'h22;
    mem[32'h01236] = 8'h33;
    mem[32'h01237] = 8'h44;
    xfer_dual(24'h001234, 4, r0);
    for (int k = 0; k < 4; k++) begin
      exp_b = 8'h11 * 8'(k + 1);
      n_checks++;
      if (got_q[k] !== exp_b) begin
        n_fail++; $display("FAIL dual_byte%0d: got %h want %h", k, got_q[k], exp_b);
      end
      exp_a = AW'(32'h01234 + k);
      got_a = (rd_log.size() > r0 + k) ? rd_log[r0 + k] : '1;
      n_checks++;
      if (rd_log.size() <= r0 + k || got_a !== exp_a) begin
        n_fail++; $display("FAIL dual_rd_addr%0d: got %h want %h", k, got_a, exp_a);
      end
    end
    n_checks++;
    if (oe_bad != 0) begin
      n_fail++; $display("FAIL dual_io_oe: got %0d bad samples want 0", oe_bad);
    end
  endtask

  task automatic test_wrap();
    int r0;
    logic [AW-1:0] exp_a [4];
    logic [AW-1:0] got_a;
    logic [7:0]    exp_b;
    exp_a[0] = 20'hFFFFE;
    exp_a[1] = 20'hFFFFF;
    exp_a[2] = 20'h00000;
    exp_a[3] = 20'h00001;
    xfer_dual(24'hFFFFFE, 4, r0);
    for (int k = 0; k < 4; k++) begin
      got_a = (rd_log.size() > r0 + k) ? rd_log[r0 + k] : '1;
      n_checks++;
      if (rd_log.size() <= r0 + k || got_a !== exp_a[k]) begin
        n_fail++; $display("FAIL wrap_rd_addr%0d: got %h want %h", k, got_a, exp_a[k]);
      end
      exp_b = store_rd({12'd0, exp_a[k]});
      n_checks++;
      if (got_q[k] !== exp_b) begin
        n_fail++; $display("FAIL wrap_byte%0d: got %h want %h", k, got_q[k], exp_b);
      end
    end
  endtask

  task automatic test_random_reads();
    int r0, n;
    logic [23:0]   a;
    int unsigned   ba;
    logic [AW-1:0] got_a;
    for (int it = 0; it < 4; it++) begin
      a = 24'($urandom());
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) mem[(32'(a[AW-1:0]) + k) & AMask] = 8'($urandom());
      xfer_dual(a, n, r0);
      for (int k = 0; k < n; k++) begin
        ba = (32'(a[AW-1:0]) + k) & AMask;
        n_checks++;
        if (got_q[k] !== store_rd(ba)) begin
          n_fail++;
          $display("FAIL rand%0d_byte%0d: got %h want %h", it, k, got_q[k], store_rd(ba));
        end
        got_a = (rd_log.size() > r0 + k) ? rd_log[r0 + k] : '1;
        n_checks++;
        if (rd_log.size() <= r0 + k || got_a !== AW'(ba)) begin
          n_fail++; $display("FAIL rand%0d_rd_addr%0d: got %h want %h", it, k, got_a, AW'(ba));
        end
      end
      n_checks++;
      if (oe_bad != 0) begin
        n_fail++; $display("FAIL rand%0d_io_oe: got %0d bad samples want 0", it, oe_bad);
      end
    end
  endtask

  task automatic test_bad_opcode();
    int unsigned e0, o0;
    int r0;
    e0 = err_cnt;
    o0 = oe_cnt;
    cs_low();
    send_op(8'h9F);
    send_cycles(40, 2'b11);
    cs_high();
    n_checks++;
    if (err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL badop_cmd_err: got %0d pulse cycles want 1", err_cnt - e0);
    end
    n_checks++;
    if (oe_cnt != o0) begin
      n_fail++; $display("FAIL badop_io_oe: got %0d driven cycles want 0", oe_cnt - o0);
    end
    mem[32'h00200] = 8'($urandom());
    mem[32'h00201] = 8'($urandom());
    xfer_dual(24'h000200, 2, r0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (got_q[k] !== store_rd(32'h200 + k)) begin
        n_fail++;
        $display("FAIL badop_next_byte%0d: got %h want %h", k, got_q[k], store_rd(32'h200 + k));
      end
    end
  endtask

  task automatic test_abort();
    logic [1:0] g, oe;
    int r0;
    mem[32'h10] = 8'($urandom());
    mem[32'h11] = 8'($urandom());
    mem[32'h12] = 8'($urandom());
    // abort during the address phase
    cs_low();
    send_op(8'hBB);
    send_cycles(5, 2'b10);
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.io_oe !== 2'b00 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_addr: got oe=%b busy=%b want oe=00 busy=0",
                         bus.io_oe, bus.busy);
    end
    repeat (6) @(negedge clk);
    // abort while driving data; CS rises in the same sample as a falling SPI edge
    cs_low();
    send_op(8'hBB);
    send_addr_dual(24'h000010);
    send_cycles(4, 2'b11);
    for (int i = 0; i < 6; i++) spi_cycle(2'b00, g, oe);
    n_checks++;
    if (oe !== 2'b11) begin
      n_fail++; $display("FAIL abort_data_driving: got %b want 11", oe);
    end
    bus.spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.io_oe !== 2'b00 || bus.io_out !== 2'b00) begin
      n_fail++; $display("FAIL abort_data_release: got oe=%b out=%b want 00 00",
                         bus.io_oe, bus.io_out);
    end
    repeat (6) @(negedge clk);
    xfer_dual(24'h000010, 3, r0);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_q[k] !== store_rd(32'h10 + k)) begin
        n_fail++;
        $display("FAIL abort_reread_byte%0d: got %h want %h", k, got_q[k], store_rd(32'h10 + k));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, oe;
    int unsigned o0;
    int r0, l0;
    logic [23:0] a;
    cs_low();
    send_op(8'hBB);
    send_addr_dual(24'h000040);
    send_cycles(4, 2'b11);
    for (int i = 0; i < 6; i++) spi_cycle(2'b00, g, oe);
    #1 RESET = 1'b1;
    #1;
    n_checks++;
    if (bus.io_out !== 2'b00 || bus.io_oe !== 2'b00 || bus.rd_en !== 1'b0 ||
        bus.busy !== 1'b0 || bus.cmd_err !== 1'b0 || bus.rd_addr !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got out=%b oe=%b rd_en=%b busy=%b err=%b addr=%h want 0",
               bus.io_out, bus.io_oe, bus.rd_en, bus.busy, bus.cmd_err, bus.rd_addr);
    end
    @(negedge clk);
    RESET = 1'b0;
    o0 = oe_cnt;
    l0 = rd_log.size();
    // CS still low: keep clocking, nothing may happen
    send_cycles(12, 2'b01);
    n_checks++;
    if (oe_cnt != o0 || rd_log.size() != l0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_quiet: got oe=%0d rd=%0d busy=%b want 0 0 0",
                         oe_cnt - o0, rd_log.size() - l0, bus.busy);
    end
    cs_high();
    a = 24'($urandom());
    mem[32'(a[AW-1:0])] = 8'($urandom());
    xfer_dual(a, 1, r0);
    n_checks++;
    if (got_q[0] !== store_rd(32'(a[AW-1:0]))) begin
      n_fail++;
      $display("FAIL midreset_next_read: got %h want %h", got_q[0], store_rd(32'(a[AW-1:0])));
    end
  endtask

  task automatic test_fastread();
    logic [1:0] g, oe;
    logic [23:0] a;
    a = 24'h000100;
    mem[32'h100] = 8'($urandom());
    mem[32'h101] = 8'($urandom());
`ifdef SPI_FLASH_RESPONDER_FASTREAD_EN
    begin
      int r0;
      logic [7:0]    b;
      logic [AW-1:0] got_a;
      oe_bad = 0;
      r0 = rd_log.size();
      cs_low();
      send_op(8'h0B);
      for (int i = 23; i >= 0; i--) spi_cycle({1'b0, a[i]}, g, oe);
      send_cycles(8, 2'b00);
      for (int k = 0; k < 2; k++) begin
        b = '0;
        for (int i = 0; i < 8; i++) begin
          spi_cycle(2'b00, g, oe);
          b = {b[6:0], g[1]};
          if (oe !== 2'b10) oe_bad++;
        end
        n_checks++;
        if (b !== store_rd(32'h100 + k)) begin
          n_fail++; $display("FAIL fast_byte%0d: got %h want %h", k, b, store_rd(32'h100 + k));
        end
        got_a = (rd_log.size() > r0 + k) ? rd_log[r0 + k] : '1;
        n_checks++;
        if (rd_log.size() <= r0 + k || got_a !== AW'(32'h100 + k)) begin
          n_fail++; $display("FAIL fast_rd_addr%0d: got %h want %h", k, got_a, AW'(32'h100 + k));
        end
      end
      cs_high();
      n_checks++;
      if (oe_bad != 0) begin
        n_fail++; $display("FAIL fast_io_oe: got %0d bad samples want 0", oe_bad);
      end
    end
`else
    begin
      int unsigned e0, o0;
      e0 = err_cnt;
      o0 = oe_cnt;
      cs_low();
      send_op(8'h0B);
      for (int i = 23; i >= 0; i--) spi_cycle({1'b0, a[i]}, g, oe);
      send_cycles(16, 2'b00);
      cs_high();
      n_checks++;
      if (err_cnt - e0 != 1) begin
        n_fail++; $display("FAIL fast_off_cmd_err: got %0d want 1", err_cnt - e0);
      end
      n_checks++;
      if (oe_cnt != o0) begin
        n_fail++; $display("FAIL fast_off_io_oe: got %0d driven cycles want 0", oe_cnt - o0);
      end
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_dual_read();
    test_wrap();
    test_random_reads();
    test_bad_opcode();
    test_abort();
    test_reset_mid();
    test_fastread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

Synthesizable SPI NOR flash emulator that answers the dual-I/O read transactions issued by the SoC's memory-mapped SPI flash reader. It sits on the flash-side pins (or a loopback in test/bring-up builds) and serves bytes from an external synchronous byte store. This lets firmware execute "from flash" without a physical flash part. The block is oversampled: all SPI pins are synchronized into `clk`, and `clk` must run at least 8× the SPI clock.

## Interface
Parameters:
- `ADDR_WIDTH`, 20: byte-address bits forwarded to the store; upper bits of the 24-bit SPI address are ignored.

Ports:
- `clk` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `spi_clk` in 1: SPI clock from initiator, mode 0 (idle low).
- `spi_cs_n` in 1: chip select, active low.
- `io_in` in 2: pad inputs; bit0 = MOSI/IO0, bit1 = MISO/IO1.
- `io_out` out 2: pad output values.
- `io_oe` out 2: pad output enables, 1 = drive.
- `rd_en` out 1: byte-store read strobe, one cycle.
- `rd_addr` out ADDR_WIDTH: byte address.
- `rd_data` in 8: store data, valid exactly 1 `clk` after `rd_en`.
- `busy` out 1: high from synchronized CS fall to synchronized CS rise.
- `cmd_err` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- Sync: 2-flop synchronizers on `spi_clk`, `spi_cs_n`, `io_in`. Rising/falling edges are detected on the synchronized `spi_clk`. All actions below refer to these detected edges.
- Inputs are sampled on rising edges. Outputs change only on falling edges.
- FSM states: IDLE, CMD, ADDR, MODE, DATA, IGNORE.
  - IDLE: on CS low, go to CMD with bit counter = 0.
  - CMD: shift IO0, MSB first, on 8 rising edges.
    - Opcode 0xBB: go to ADDR.
    - Opcode 0x0B (macro only): go to ADDR_S.
    - Any other opcode: pulse `cmd_err`, go to IGNORE.
  - ADDR: 12 rising edges, 2 bits each. IO1 carries the higher bit of each pair (bits 23,21,…,1); IO0 carries bits 22,20,…,0.
  - On completion of ADDR: issue `rd_en` with `rd_addr` = `addr[ADDR_WIDTH-1:0]`, then go to MODE.
  - MODE: 4 rising edges. Mode bits are ignored; continuous-read mode is not supported.
  - DATA entry: on the falling edge after the 4th MODE rising edge, set `io_oe` = 2'b11 and drive bits [7:6] of the fetched byte.
  - DATA shifting: each following falling edge drives the next dibit ([5:4], [3:2], [1:0]). Bytes are sent in address order, MSB first.
  - Prefetch: when dibit [7:6] of byte N is driven, issue `rd_en` for N+1. The prefetched byte is latched into a holding register and loaded into the shifter at the byte boundary.
  - Address increments modulo 2^ADDR_WIDTH, so reads wrap silently past the top of the store.
  - IGNORE: outputs stay released until CS goes high.
- CS high from any state (including mid-byte or mid-address): go to IDLE; on the same `clk`, set `io_oe` = 0, `io_out` = 0, and clear the counters. No partial byte is retained.
- `RESET` while active: same as CS high, applied asynchronously. If CS is still low at release, the FSM waits in IDLE for a fresh CS fall, so a mid-transaction reset never resumes.

## Timing
- Reset values: `io_out` = 0, `io_oe` = 0, `rd_en` = 0, `rd_addr` = 0, `busy` = 0, `cmd_err` = 0. FSM in IDLE; all counters 0.
- Pin-to-action latency: 3 `clk` cycles (2 sync stages + edge register). Pin drive changes 3–4 `clk` after the `spi_clk` falling pin edge.
- Store latency: 1 `clk`. The first byte is available ≥ 4 SPI periods before it is needed. A prefetch has 4 SPI periods of margin, which is ample at the 8× ratio.
- `busy` rises 3 `clk` after the CS pin falls and falls 3 `clk` after the CS pin rises.
- `io_oe` = 0 is guaranteed no later than 3 `clk` after CS rises.
- Simultaneous CS rise and `spi_clk` edge in the same sample: CS wins, and the edge is discarded.

## Configuration
- `SPI_FLASH_RESPONDER_FASTREAD_EN`: when defined, opcode 0x0B (single-I/O fast read) is also accepted:
  - ADDR_S: 24 rising edges on IO0, MSB first.
  - DUMMY: 8 rising edges.
  - DATA_S: `io_oe` = 2'b10, data on IO1 one bit per falling edge, MSB first. Prefetch occurs at bit 7.
- When undefined, 0x0B is treated as an unsupported opcode (pulse `cmd_err`, go to IGNORE) and the extra states and counter width are not synthesized.

## Test plan
- Store[0x01234] = 0x11, 0x22, 0x33, 0x44. Send 0xBB, address 0x001234, mode 0xFF, then 16 data clocks → IO[1:0] dibits decode to bytes 0x11, 0x22, 0x33, 0x44; `rd_addr` sequence 0x01234…0x01237.
- ADDR_WIDTH = 20, address 0xFFFFFE, read 4 bytes → `rd_addr` sequence 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Opcode 0x9F → one `cmd_err` pulse; `io_oe` stays 0 for the whole transaction; the next 0xBB transaction reads correctly.
- CS raised after 5 address clocks, then a full 0xBB read of 0x000010 → `io_oe` = 0 within 3 `clk` of the CS rise; the second read returns Store[0x10] with no corruption.
- `RESET` pulsed during DATA with CS held low → all outputs 0; no output activity until CS goes high then low again.
- With `SPI_FLASH_RESPONDER_FASTREAD_EN`: 0x0B, address 0x000100, 8 dummy clocks → IO1 serializes Store[0x100] MSB first, `io_oe` = 2'b10. Without the macro: same stimulus → `cmd_err` pulse, `io_oe` stays 0.
